// File: rtl/mem_access_ctrl_if.sv
// Signal bundle between the memory-stage sequencer, the EX/MEM register,
// the data cache and the MEM/WB register.
interface mem_access_ctrl_if;
    logic        ex_valid;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_halt;
    logic [31:0] ex_addr;
    logic [31:0] ex_store;
    logic        dhit;
    logic [31:0] dmemload_in;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dmemload_out;
    logic        mwb_WEN;
    logic        mwb_flush;
    logic        mem_stall;
    logic        halt_out;
    logic        err_timeout;

    modport master (
        input  ex_valid, ex_MemRead, ex_MemWrite, ex_halt, ex_addr, ex_store,
        input  dhit, dmemload_in,
        output dREN, dWEN, daddr, dstore, dmemload_out,
        output mwb_WEN, mwb_flush, mem_stall, halt_out, err_timeout
    );

    modport slave (
        output ex_valid, ex_MemRead, ex_MemWrite, ex_halt, ex_addr, ex_store,
        output dhit, dmemload_in,
        input  dREN, dWEN, daddr, dstore, dmemload_out,
        input  mwb_WEN, mwb_flush, mem_stall, halt_out, err_timeout
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer: issues dcache requests, stalls upstream
// until dhit, drives MEM/WB enable/flush and latches HALT.
module mem_access_ctrl #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic               CLK,
    input  logic               nRST,
    mem_access_ctrl_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] load_q, load_d;
    logic        wr_q, wr_d;
    logic        hreq_q, hreq_d;
    logic        halt_q, halt_d;
    logic        err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        mem_op;
    logic        dren, dwen;
    logic [31:0] daddr, dstore;
    logic        mwb_wen, mwb_flush, mem_stall;

    assign mem_op = bus.ex_valid & (bus.ex_MemRead | bus.ex_MemWrite);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = wr_q;
        hreq_d    = hreq_q;
        halt_d    = halt_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        load_d    = bus.dhit ? bus.dmemload_in : load_q;

        dren      = 1'b0;
        dwen      = 1'b0;
        daddr     = 32'h0;
        dstore    = 32'h0;
        mwb_wen   = 1'b0;
        mwb_flush = 1'b0;
        mem_stall = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    // A simultaneous read+write request is treated as a store.
                    dwen   = bus.ex_MemWrite;
                    dren   = ~bus.ex_MemWrite;
                    daddr  = bus.ex_addr;
                    dstore = bus.ex_store;
                    addr_d = bus.ex_addr;
                    data_d = bus.ex_store;
                    wr_d   = bus.ex_MemWrite;
                    hreq_d = bus.ex_halt;
                    if (bus.dhit) begin
                        mwb_wen = 1'b1;
                        if (bus.ex_halt) begin
                            halt_d  = 1'b1;
                            state_d = HALTED;
                        end
                    end else begin
                        mem_stall = 1'b1;
                        mwb_flush = 1'b1;
                        state_d   = BUSY;
                    end
                end else if (bus.ex_valid && bus.ex_halt) begin
                    mwb_wen = 1'b1;
                    halt_d  = 1'b1;
                    state_d = HALTED;
                end else begin
                    mwb_wen = 1'b1;
                end
            end

            BUSY: begin
                dwen   = wr_q;
                dren   = ~wr_q;
                daddr  = addr_q;
                dstore = data_q;
                if (bus.dhit) begin
                    mwb_wen = 1'b1;
                    cnt_d   = '0;
                    if (hreq_q) begin
                        halt_d  = 1'b1;
                        state_d = HALTED;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    mem_stall = 1'b1;
                    mwb_flush = 1'b1;
                    if (cnt_q < CNT_W'(MAX_WAIT)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // The request is not abandoned on timeout; only the flag latches.
                    if (cnt_d == CNT_W'(MAX_WAIT)) begin
                        err_d = 1'b1;
                    end
                end
            end

            HALTED: begin
                mem_stall = 1'b1;
                mwb_flush = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is held the request is dropped and MEM/WB gets bubbles.
        if (nRST) begin
            dren      = 1'b0;
            dwen      = 1'b0;
            daddr     = 32'h0;
            dstore    = 32'h0;
            mwb_wen   = 1'b0;
            mwb_flush = 1'b1;
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            load_q  <= 32'h0;
            wr_q    <= 1'b0;
            hreq_q  <= 1'b0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            load_q  <= load_d;
            wr_q    <= wr_d;
            hreq_q  <= hreq_d;
            halt_q  <= halt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.dREN         = dren;
    assign bus.dWEN         = dwen;
    assign bus.daddr        = daddr;
    assign bus.dstore       = dstore;
    assign bus.dmemload_out = bus.dhit ? bus.dmemload_in : load_q;
    assign bus.mwb_WEN      = mwb_wen;
    assign bus.mwb_flush    = mwb_flush;
    assign bus.mem_stall    = mem_stall;
    assign bus.halt_out     = halt_q;
    assign bus.err_timeout  = err_q;

    a_wen_flush_excl: assert property (@(posedge CLK) !(mwb_wen && mwb_flush));
    a_ren_wen_excl:   assert property (@(posedge CLK) !(dren && dwen));

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access sequencer that sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It issues data-cache read/write requests for load/store instructions and holds them until the cache returns `dhit`. It stalls upstream stages while a request is outstanding and generates the write-enable/flush controls that load the MEM/WB register. It also latches halt so the pipeline drains and freezes cleanly.

## Interface
- `MAX_WAIT`, default 64: wait-cycle count at which `err_timeout` is set.
- `CLK`  in  1  clock; all state updates on rising edge.
- `nRST`  in  1  **synchronous, active-high** reset: asserted = 1, sampled on `CLK` rising edge.
- `ex_valid`  in  1  EX/MEM holds a real (non-bubble) instruction.
- `ex_MemRead`  in  1  instruction is a load.
- `ex_MemWrite`  in  1  instruction is a store.
- `ex_halt`  in  1  instruction is HALT.
- `ex_addr`  in  32  data address (ALU output).
- `ex_store`  in  32  store data.
- `dhit`  in  1  dcache completes the current request this cycle.
- `dmemload_in`  in  32  dcache read data, valid when `dhit`=1.
- `dREN`  out  1  dcache read request.
- `dWEN`  out  1  dcache write request.
- `daddr`  out  32  dcache address.
- `dstore`  out  32  dcache write data.
- `dmemload_out`  out  32  load data toward MEM/WB.
- `mwb_WEN`  out  1  MEM/WB load enable.
- `mwb_flush`  out  1  MEM/WB bubble insert; clears RegWrite/MemRead/pcn there.
- `mem_stall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- `halt_out`  out  1  sticky halt indication.
- `err_timeout`  out  1  sticky; a request waited ≥ `MAX_WAIT` cycles.

## Operation
- A memory op is `ex_valid & (ex_MemRead | ex_MemWrite)`. If both are set, the op is a write: `dWEN`=1, `dREN`=0.
- FSM states:
  - **IDLE**
    - Memory op:
      - Drive `dREN`/`dWEN`, `daddr`=`ex_addr`, `dstore`=`ex_store` combinationally.
      - Capture addr, data, and type into request registers.
      - With `dhit`=1 the same cycle: `mwb_WEN`=1, `mem_stall`=0, stay in IDLE.
      - With no hit: `mem_stall`=1, `mwb_flush`=1, `mwb_WEN`=0, go to BUSY.
    - HALT with no memory op: `mwb_WEN`=1 (the halt passes into MEM/WB), set `halt_out`, go to HALTED.
    - Any other input, valid or bubble: `mwb_WEN`=1, `mem_stall`=0, request outputs low.
  - **BUSY**
    - Drive the request from the captured registers, not from `ex_*`.
    - `mem_stall`=1 and `mwb_flush`=1 every cycle without a hit.
    - Wait counter increments each non-hit cycle, saturating at `MAX_WAIT`. Reaching `MAX_WAIT` sets `err_timeout`; the request keeps waiting.
    - On `dhit`: `mwb_WEN`=1, `mwb_flush`=0, `mem_stall`=0, counter cleared, go to IDLE.
  - **HALTED**
    - `dREN`=`dWEN`=0, `mem_stall`=1, `mwb_flush`=1, `mwb_WEN`=0, `halt_out`=1.
    - Left only by reset.
- `dmemload_out` equals `dmemload_in` in any cycle where `dhit`=1. Otherwise it holds the last hit value in a register.
- `mwb_WEN` and `mwb_flush` are never both 1.
- A load/store that also has `ex_halt` completes the access first. `halt_out` then sets on the cycle after the hit.

## Timing
- Reset, while `nRST`=1 at the edge:
  - State → IDLE; counter, `err_timeout`, `halt_out`, and the captured-request registers (including the `dmemload_out` holding register) → 0.
  - While `nRST` is high, outputs are forced to: `dREN`=`dWEN`=0, `daddr`=`dstore`=0, `mwb_WEN`=0, `mwb_flush`=1, `mem_stall`=0.
- Reset mid-BUSY abandons the request: request outputs drop in the reset cycle, and no `mwb_WEN` is issued for it.
- Hit latency: same-cycle hit adds 0 stall cycles. A hit arriving N cycles after issue gives exactly N `mem_stall`=1 cycles, followed by one `mwb_WEN` cycle.
- Back-to-back memory ops: the op following a hit cycle is issued in the very next cycle from IDLE, with no idle gap.
- `dhit` is ignored in IDLE when no memory op is present.
- `dhit` is ignored in HALTED.

## Test plan
- **Idle pass-through:** non-memory valid ALU op, `dhit`=0 → `mwb_WEN`=1, `mem_stall`=0, `dREN`=`dWEN`=0.
- **Load, 3-cycle miss:**
  - Stimulus: load to `ex_addr`=0x0000_0040, `dhit` asserted on the 4th cycle with `dmemload_in`=0xDEAD_BEEF.
  - Required: `dREN`=1 and `daddr`=0x40 in all 4 cycles; `mem_stall`=1 and `mwb_flush`=1 for 3 cycles; then `mwb_WEN`=1 and `dmemload_out`=0xDEAD_BEEF.
- **Store with EX inputs changed during BUSY:**
  - Stimulus: store of 0x1234_5678 to 0x80; inputs change to 0xFFFF_FFFF at 0x100 while waiting.
  - Required: `dWEN`=1, `daddr`=0x80, `dstore`=0x1234_5678 are held until `dhit`.
- **Timeout:** `MAX_WAIT`=4, no `dhit` for 6 cycles → `err_timeout` rises after the 4th wait cycle and stays 1 after a later hit.
- **Halt:** HALT with `ex_valid`=1 → one `mwb_WEN`=1 cycle, then `halt_out`=1 and `mem_stall`=1 permanently; a later `dhit` produces no `mwb_WEN`.
- **Reset mid-miss:** `nRST`=1 on the 2nd BUSY cycle → next cycle IDLE, `dREN`=0, counter 0, no `mwb_WEN` for the dropped load.
